// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin share of the async FIFO write port across NUM_REQ requesters, plus fill level.
// Latency : zero cycles valid->write (combinational grant); almost_full registered one cycle after level.
// Backpressure: fifo_full blocks every transfer and freezes arbitration state; req_ready is one-hot or zero.
// Optional packet locking is built when WR_ARB_PKT_LOCK_EN is defined; otherwise arbitration is per word.
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int PTR_WIDTH    = 3,
    parameter int AFULL_THRESH = 6,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic [PTR_WIDTH:0]            b_wptr,
    input  logic [PTR_WIDTH:0]            g_rptr_sync,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [IDW-1:0]                grant_id,
    output logic [PTR_WIDTH:0]            level,
    output logic                          almost_full
);

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam logic [IDW:0]       NREQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW:0]       ONE_W  = (IDW+1)'(1);
    localparam logic [PTR_WIDTH:0] AFT_W  = (PTR_WIDTH+1)'(AFULL_THRESH);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel_idle;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] sel_next;
    logic [IDW:0]   cand;
    logic [IDW:0]   nxt;
    logic           found;
    logic [PTR_WIDTH:0] rptr_bin;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_idle = rr_ptr;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + i[IDW:0];
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!found && req_valid[cand[IDW-1:0]]) begin
                sel_idle = cand[IDW-1:0];
                found    = 1'b1;
            end
        end
    end

    // A locked owner keeps the port even while it is not presenting a word.
    always_comb begin
        sel = (state == LOCKED) ? grant_id : sel_idle;
    end

    // Pointer that makes the requester after the winner first in line next time.
    always_comb begin
        nxt = {1'b0, sel} + ONE_W;
        if (nxt == NREQ_W) begin
            nxt = '0;
        end
        sel_next = nxt[IDW-1:0];
    end

    assign fifo_w_en  = req_valid[sel] & ~fifo_full;
    assign fifo_wdata = req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

    // Only the selected requester sees ready, and only when its word is actually written.
    always_comb begin
        req_ready = '0;
        if (fifo_w_en) begin
            req_ready[sel] = 1'b1;
        end
    end

`ifdef WR_ARB_PKT_LOCK_EN
    // Packet-lock FSM: a non-last word claims the port until the owner's last word goes through.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (fifo_w_en) begin
            case (state)
                IDLE: begin
                    grant_id <= sel;
                    if (req_last[sel]) begin
                        rr_ptr <= sel_next;
                    end else begin
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (req_last[sel]) begin
                        state  <= IDLE;
                        rr_ptr <= sel_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Packet boundaries do not matter in per-word arbitration.
    logic unused_last;
    assign unused_last = ^req_last;

    // Per-word round-robin: every transfer records the winner and moves priority past it.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (fifo_w_en) begin
            state    <= IDLE;
            grant_id <= sel;
            rr_ptr   <= sel_next;
        end
    end
`endif

    // Gray-to-binary of the synchronized read pointer by prefix XOR from the MSB down.
    always_comb begin
        rptr_bin            = '0;
        rptr_bin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            rptr_bin[i] = rptr_bin[i+1] ^ g_rptr_sync[i];
        end
    end

    // Extra pointer bit makes the modulo subtraction correct across wrap-around.
    assign level = b_wptr - rptr_bin;

    // Registered threshold flag keeps the requester-facing timing path short.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level >= AFT_W);
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (4 requesters, 8-bit data, depth 8).
// Inputs change on the falling edge and outputs are sampled 1 ns later; state commits on the rising edge.
// Expected grant orders for the packet scenario depend on whether WR_ARB_PKT_LOCK_EN is built in.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic [3:0]  b_wptr;
    logic [3:0]  g_rptr_sync;
    logic        fifo_w_en;
    logic [7:0]  fifo_wdata;
    logic [1:0]  grant_id;
    logic [3:0]  level;
    logic        almost_full;

    logic [7:0]  dat [4];

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (8),
        .PTR_WIDTH    (3),
        .AFULL_THRESH (6)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .b_wptr      (b_wptr),
        .g_rptr_sync (g_rptr_sync),
        .fifo_w_en   (fifo_w_en),
        .fifo_wdata  (fifo_wdata),
        .grant_id    (grant_id),
        .level       (level),
        .almost_full (almost_full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    always_comb req_data = {dat[3], dat[2], dat[1], dat[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full transfer check: write enable, one-hot ready, data from the expected requester.
    task automatic chk_xfer(input string tag, input int who);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << who;
        chk({tag, ".w_en"},  32'(fifo_w_en),  32'd1);
        chk({tag, ".ready"}, 32'(req_ready),  32'(exp_rdy));
        chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(dat[who]));
    endtask

    task automatic chk_none(input string tag);
        chk({tag, ".w_en"},  32'(fifo_w_en), 32'd0);
        chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        int exp_g;
        wrst_n      = 1'b0;
        req_valid   = '0;
        req_last    = '0;
        fifo_full   = 1'b0;
        b_wptr      = '0;
        g_rptr_sync = '0;
        for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);

        // Reset state
        @(negedge wclk);
        @(negedge wclk); #1;
        chk("rst.grant",  32'(grant_id),    32'd0);
        chk("rst.afull",  32'(almost_full), 32'd0);
        chk("rst.level",  32'(level),       32'd0);
        chk_none("rst");

        // 1: all valid, single-word packets -> 0,1,2,3,0
        @(negedge wclk);
        wrst_n    = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge wclk);
            #1;
            chk_xfer($sformatf("rr%0d", k), k % 4);
            chk($sformatf("rr%0d.grant", k), 32'(grant_id), 32'((k == 0) ? 0 : (k - 1) % 4));
        end

        // 2: req1 sends a 3-word packet while req0 and req2 are valid (priority now at req1)
        @(negedge wclk);
        req_valid = 4'b0111;
        req_last  = 4'b1101;
        dat[1]    = 8'h10;
        #1; chk_xfer("pkt.a", 1);
`ifdef WR_ARB_PKT_LOCK_EN
        @(negedge wclk);
        dat[1] = 8'h11;
        #1; chk_xfer("pkt.b", 1);
        chk("pkt.b.grant", 32'(grant_id), 32'd1);
        // owner drops valid mid-packet: everyone else still stalls
        @(negedge wclk);
        req_valid = 4'b0101;
        #1; chk_none("pkt.gap");
        @(negedge wclk);
        req_valid = 4'b0111;
        req_last  = 4'b1111;
        dat[1]    = 8'h12;
        #1; chk_xfer("pkt.c", 1);
        @(negedge wclk);
        req_valid = 4'b0101;
        #1; chk_xfer("pkt.d", 2);
        exp_g = 2;
`else
        @(negedge wclk);
        dat[1] = 8'h11;
        #1; chk_xfer("pkt.b", 2);
        @(negedge wclk); #1;
        chk_xfer("pkt.c", 0);
        @(negedge wclk); #1;
        chk_xfer("pkt.d", 1);
        req_last = 4'b1111;
        exp_g = 1;
`endif
        @(negedge wclk);
        req_valid = '0;
        dat[1]    = 8'hA1;
        #1; chk_none("idle");
        chk("idle.grant", 32'(grant_id), 32'(exp_g));

        // 3: fifo_full for 5 cycles with req3 valid
        @(negedge wclk);
        req_valid = 4'b1000;
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge wclk);
            #1;
            chk_none($sformatf("full%0d", k));
            chk($sformatf("full%0d.grant", k), 32'(grant_id), 32'(exp_g));
        end
        @(negedge wclk);
        fifo_full = 1'b0;
        #1; chk_xfer("full.rel", 3);
        // all valid under full: priority must still be at req0 afterwards
        @(negedge wclk);
        req_valid = 4'hF;
        fifo_full = 1'b1;
        #1; chk_none("full2.a");
        @(negedge wclk); #1;
        chk_none("full2.b");
        @(negedge wclk);
        fifo_full = 1'b0;
        #1; chk_xfer("full2.rel", 0);
        chk("full2.grant", 32'(grant_id), 32'd3);

        // 4: level and almost_full
        @(negedge wclk);
        req_valid   = '0;
        b_wptr      = 4'b0010;
        g_rptr_sync = 4'b1010;
        #1; chk("lvl6", 32'(level), 32'd6);
        chk("lvl6.af_prev", 32'(almost_full), 32'd0);
        @(negedge wclk); #1;
        chk("lvl6.af", 32'(almost_full), 32'd1);
        @(negedge wclk);
        g_rptr_sync = 4'b0011;
        #1; chk("lvl0", 32'(level), 32'd0);
        @(negedge wclk); #1;
        chk("lvl0.af", 32'(almost_full), 32'd0);
        @(negedge wclk);
        b_wptr      = 4'b0101;
        g_rptr_sync = 4'b0000;
        #1; chk("lvl5", 32'(level), 32'd5);
        @(negedge wclk); #1;
        chk("lvl5.af", 32'(almost_full), 32'd0);
        @(negedge wclk);
        b_wptr      = 4'b0001;
        g_rptr_sync = 4'b1000;
        #1; chk("lvl.wrap", 32'(level), 32'd2);
        @(negedge wclk);
        b_wptr      = 4'b1000;
        g_rptr_sync = 4'b0000;
        #1; chk("lvl8", 32'(level), 32'd8);
        @(negedge wclk); #1;
        chk("lvl8.af", 32'(almost_full), 32'd1);

        // 5: reset mid-packet from req2
        @(negedge wclk);
        req_valid = 4'b0100;
        req_last  = 4'b1011;
        dat[2]    = 8'h20;
        #1; chk_xfer("mid.a", 2);
        @(negedge wclk);
        wrst_n    = 1'b0;
        req_valid = '0;
        b_wptr    = '0;
        #1; chk("mid.rst.grant", 32'(grant_id),    32'd0);
        chk("mid.rst.afull",     32'(almost_full), 32'd0);
        chk_none("mid.rst");
        @(negedge wclk);
        wrst_n    = 1'b1;
        req_valid = 4'b0101;
        req_last  = 4'hF;
        dat[2]    = 8'h21;
        #1; chk_xfer("mid.r0", 0);
        @(negedge wclk); #1;
        chk_xfer("mid.r2", 2);

        // 6: only req2, with idle gaps
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            req_valid = (k == 1 || k == 4) ? 4'b0000 : 4'b0100;
            dat[2]    = 8'h30 + 8'(k);
            #1;
            if (req_valid[2]) chk_xfer($sformatf("gap%0d", k), 2);
            else              chk_none($sformatf("gap%0d", k));
            chk($sformatf("gap%0d.grant", k), 32'(grant_id), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
